uart_rx: RTL and testbench

8N1 UART receiver that consumes the 8x-oversampled `baud_tick` pulse stream from the baud-rate generator and converts the serial `rx` line into parallel bytes. It sits between the asynchronous board pin and the byte-consuming logic (FIFO, command parser). It has no flow control: each received byte is presented with a one-clock `rx_done` strobe.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared UART types and default framing constants.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_OVERSAMPLE = 8;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// Module : sync_2ff
// Brief  : Generic two-flop synchronizer with configurable reset value.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module : uart_rx
// Brief  : 8N1 UART receiver driven by an oversampled baud tick.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] c_tick_mid  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(DATA_BITS - 1);

  logic rx_sync;

  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q,  tick_d;
  logic [BIT_W-1:0]     bit_q,   bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 ferr_q,  ferr_d;
  logic                 done_q,  done_d;

  // Idle line is high, so the synchronizer comes out of reset at 1.
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_sync) begin
            state_d = START;
            tick_d  = '0;
          end
        end

        START: begin
          if (tick_q == c_tick_mid) begin
            tick_d = '0;
            if (!rx_sync) begin
              state_d = DATA;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end

        DATA: begin
          if (tick_q == c_tick_last) begin
            // LSB arrives first, so shifting right leaves it at bit 0.
            shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_q == c_bit_last) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end

        STOP: begin
          if (tick_q == c_tick_last) begin
            data_d  = shift_q;
            ferr_d  = ~rx_sync;
            done_d  = 1'b1;
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule : uart_rx

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module : tb_uart_rx
// Brief  : Directed self-checking bench for uart_rx.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx        = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  int tick_div = 4;
  int tdiv     = 0;
  int cyc      = 0;

  int         done_cnt      = 0;
  int         busy_cnt      = 0;
  int         done_cyc_prev = 0;
  int         done_cyc_last = 0;
  logic [7:0] last_data     = 8'h00;
  logic [7:0] prev_data     = 8'h00;
  logic       last_ferr     = 1'b0;

  int         n0;
  int         b0;
  int         bd;
  logic [7:0] d0;

  uart_rx #(
    .OVERSAMPLE (8),
    .DATA_BITS  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick source: one-clock pulse every tick_div clocks, changed on falling edges.
  always @(negedge clk) begin
    if (tdiv >= tick_div - 1) begin
      tdiv      = 0;
      baud_tick = 1'b1;
    end else begin
      tdiv      = tdiv + 1;
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done) begin
      prev_data     <= last_data;
      last_data     <= rx_data;
      last_ferr     <= frame_err;
      done_cyc_prev <= done_cyc_last;
      done_cyc_last <= cyc;
      done_cnt      <= done_cnt + 1;
    end
    if (rx_busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int bit_clks);
    rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx = stop_bit;
    repeat (bit_clks) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle(3);
    chk("rst_data",  {24'h0, rx_data}, 32'h00);
    chk("rst_done",  {31'h0, rx_done}, 32'h0);
    chk("rst_ferr",  {31'h0, frame_err}, 32'h0);
    chk("rst_busy",  {31'h0, rx_busy}, 32'h0);
    rst = 1'b0;
    idle(20);

    // Single clean frame
    n0 = done_cnt;
    b0 = busy_cnt;
    send_byte(8'h55, 1'b1, 32);
    idle(64);
    bd = busy_cnt - b0;
    chk("f55_count", done_cnt - n0, 1);
    chk("f55_data",  {24'h0, last_data}, 32'h55);
    chk("f55_ferr",  {31'h0, last_ferr}, 32'h0);
    chk("f55_busy_len", {31'h0, (bd >= 300 && bd <= 308)}, 32'h1);
    chk("f55_busy_end", {31'h0, rx_busy}, 32'h0);

    // Back-to-back frames with no idle gap
    n0 = done_cnt;
    send_byte(8'hA3, 1'b1, 32);
    send_byte(8'h0F, 1'b1, 32);
    idle(64);
    chk("b2b_count", done_cnt - n0, 2);
    chk("b2b_first", {24'h0, prev_data}, 32'hA3);
    chk("b2b_second", {24'h0, last_data}, 32'h0F);
    chk("b2b_gap", done_cyc_last - done_cyc_prev, 320);

    // Start-bit glitch of two ticks
    n0 = done_cnt;
    d0 = rx_data;
    rx = 1'b0;
    idle(8);
    rx = 1'b1;
    idle(2);
    chk("glitch_busy_hi", {31'h0, rx_busy}, 32'h1);
    idle(40);
    chk("glitch_busy_lo", {31'h0, rx_busy}, 32'h0);
    chk("glitch_count", done_cnt - n0, 0);
    chk("glitch_data", {24'h0, rx_data}, {24'h0, d0});

    // Framing error, then recovery
    n0 = done_cnt;
    send_byte(8'hC6, 1'b0, 32);
    idle(64);
    chk("ferr_count", done_cnt - n0, 1);
    chk("ferr_data", {24'h0, last_data}, 32'hC6);
    chk("ferr_flag", {31'h0, last_ferr}, 32'h1);
    chk("ferr_level", {31'h0, frame_err}, 32'h1);
    send_byte(8'h12, 1'b1, 32);
    idle(64);
    chk("recov_count", done_cnt - n0, 2);
    chk("recov_data", {24'h0, last_data}, 32'h12);
    chk("recov_ferr", {31'h0, frame_err}, 32'h0);

    // Reset in the middle of data bit 3 of 0xFF
    n0 = done_cnt;
    rx = 1'b0;
    idle(32);
    rx = 1'b1;
    idle(3 * 32 + 16);
    chk("pre_rst_busy", {31'h0, rx_busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_data", {24'h0, rx_data}, 32'h00);
    chk("midrst_done", {31'h0, rx_done}, 32'h0);
    chk("midrst_ferr", {31'h0, frame_err}, 32'h0);
    chk("midrst_busy", {31'h0, rx_busy}, 32'h0);
    idle(2);
    rst = 1'b0;
    idle(200);
    chk("midrst_nodone", done_cnt - n0, 0);
    chk("midrst_idle", {31'h0, rx_busy}, 32'h0);
    send_byte(8'h3C, 1'b1, 32);
    idle(64);
    chk("post_rst_count", done_cnt - n0, 1);
    chk("post_rst_data", {24'h0, last_data}, 32'h3C);
    chk("post_rst_ferr", {31'h0, last_ferr}, 32'h0);

    // Sender roughly 2% slower than the receiver's nominal bit time
    tick_div = 13;
    idle(40);
    n0 = done_cnt;
    send_byte(8'h7E, 1'b1, 106);
    idle(200);
    chk("skew_count", done_cnt - n0, 1);
    chk("skew_data", {24'h0, last_data}, 32'h7E);
    chk("skew_ferr", {31'h0, last_ferr}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx

`default_nettype wire
